// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg : operation encoding shared by alu_seq and its users.
// alu_seq     : handshaked, registered ALU with a multi-cycle shift-add multiply.
//
// Ports
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   IN_VALID / IN_READY  operand-side handshake (IN_READY is combinational)
//   OP, INPUTA, INPUTB   operation and operands, sampled only on a transfer
//   OUT_VALID/OUT_READY  result-side handshake
//   OUT                  result (WIDTH bits)
//   ZERO                 OUT == 0
//   EQUAL                latched INPUTA == latched INPUTB
//   CARRY                carry / borrow / shift-out / multiply overflow
//
// WIDTH must be a power of two in 4..64; SHW is derived from it.
// -----------------------------------------------------------------------------
package alu_seq_pkg;
    typedef enum logic [2:0] {
        kADD = 3'd0,
        kSUB = 3'd1,
        kAND = 3'd2,
        kXOR = 3'd3,
        kOR  = 3'd4,
        kSHL = 3'd5,
        kSHR = 3'd6,
        kMUL = 3'd7
    } op_e;
endpackage

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] INPUTA,
    input  logic [WIDTH-1:0] INPUTB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             ZERO,
    output logic             EQUAL,
    output logic             CARRY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   out_q;
    logic               zero_q, equal_q, carry_q, valid_q;

    op_e                op_in;
    logic               accept;
    logic [WIDTH-1:0]   res_d;
    logic               carry_d;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_last;

    assign op_in = op_e'(OP);

    // A result slot frees up in the same cycle the consumer takes the old one,
    // which is what allows one non-MUL op per cycle while streaming.
    assign IN_READY = RST_N & ((state_q == S_IDLE) |
                               ((state_q == S_DONE) & OUT_READY));
    assign accept   = IN_VALID & IN_READY;

    // Single-cycle ops are evaluated straight from the input operands so the
    // result can be registered on the accepting edge.
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        sh      = INPUTB[SHW-1:0];
        case (op_in)
            kADD: {carry_d, res_d} = {1'b0, INPUTA} + {1'b0, INPUTB};
            // Top bit of the widened difference is the borrow (A < B).
            kSUB: {carry_d, res_d} = {1'b0, INPUTA} - {1'b0, INPUTB};
            kAND: res_d = INPUTA & INPUTB;
            kXOR: res_d = INPUTA ^ INPUTB;
            kOR:  res_d = INPUTA | INPUTB;
            // Extra bit above the MSB catches A[WIDTH-s]; zero when s == 0.
            kSHL: {carry_d, res_d} = {1'b0, INPUTA} << sh;
            // Extra bit below the LSB catches A[s-1]; zero when s == 0.
            kSHR: {res_d, carry_d} = {INPUTA, 1'b0} >> sh;
            default: ;  // kMUL goes through the sequencer
        endcase
    end

    // One shift-add step per cycle, LSB of B first.
    assign partial  = {{WIDTH{1'b0}}, a_q} << cnt_q;
    assign acc_next = b_q[cnt_q] ? (acc_q + partial) : acc_q;
    assign mul_last = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            equal_q <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_q <= INPUTA;
                        b_q <= INPUTB;
                        if (op_in == kMUL) begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= S_MUL;
                        end else begin
                            out_q   <= res_d;
                            zero_q  <= (res_d == '0);
                            equal_q <= (INPUTA == INPUTB);
                            carry_q <= carry_d;
                            valid_q <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else if ((state_q == S_DONE) && OUT_READY) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    // The final step is folded into the result capture, so the
                    // product is presented right after the WIDTH-th iteration.
                    if (mul_last) begin
                        out_q   <= acc_next[WIDTH-1:0];
                        zero_q  <= (acc_next[WIDTH-1:0] == '0);
                        equal_q <= (a_q == b_q);
                        carry_q <= |acc_next[2*WIDTH-1:WIDTH];
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign OUT_VALID = valid_q;
    assign OUT       = out_q;
    assign ZERO      = zero_q;
    assign EQUAL     = equal_q;
    assign CARRY     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 16-bit instance driven with directed and random ops
// against an arithmetic reference model, plus an 8-bit instance for the
// narrow-width ADD corner.
module tb_alu_seq;

    localparam int W  = 16;
    localparam int W8 = 8;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, XOR_ = 3'd3,
                           OR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    op;
    logic [W-1:0]  ina, inb, out;
    logic          zero, equal, carry;

    logic          v8, r8, ov8, z8, e8, c8;
    logic [2:0]    op8;
    logic [W8-1:0] a8, b8, o8;

    int n_pass  = 0;
    int n_total = 0;

    alu_seq #(.WIDTH(W)) dut (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .OP(op), .INPUTA(ina), .INPUTB(inb),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT(out), .ZERO(zero), .EQUAL(equal), .CARRY(carry)
    );

    alu_seq #(.WIDTH(W8)) dut8 (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(v8), .IN_READY(r8),
        .OP(op8), .INPUTA(a8), .INPUTB(b8),
        .OUT_VALID(ov8), .OUT_READY(1'b1),
        .OUT(o8), .ZERO(z8), .EQUAL(e8), .CARRY(c8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model from the op definitions, in plain 64-bit arithmetic.
    function automatic void model(input logic [2:0] o, input longint unsigned a,
                                  input longint unsigned b, input int w,
                                  output longint unsigned r, output bit c);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned p;
        int s = int'(b % longint'(w));
        c = 1'b0;
        case (o)
            ADD:  begin p = a + b; r = p & mask; c = ((p >> w) & 1) != 0; end
            SUB:  begin r = (a - b) & mask; c = (a < b); end
            AND_: r = a & b;
            XOR_: r = a ^ b;
            OR_:  r = a | b;
            SHL:  begin r = (a << s) & mask; c = (s != 0) && (((a >> (w - s)) & 1) != 0); end
            SHR:  begin r = a >> s; c = (s != 0) && (((a >> (s - 1)) & 1) != 0); end
            default: begin p = a * b; r = p & mask; c = (p >> w) != 0; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one op, wait for the transfer, then wait for the result and
    // compare latency, IN_READY during the wait, and result/flags.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned er;
        bit ec;
        int n, lat, rdy;
        model(o, a, b, W, er, ec);
        op = o; ina = a; inb = b; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check("accept_wait", 64'(n < 100), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 0; rdy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy++;
            tick();
            lat++;
        end
        check($sformatf("latency op%0d", o), 64'(lat), (o == MUL) ? 64'(W) : 64'd0);
        check($sformatf("ready_low op%0d", o), 64'(rdy), 64'd0);
        check($sformatf("out op%0d a=%h b=%h", o, a, b), 64'(out), er);
        check($sformatf("zero op%0d", o), 64'(zero), 64'(er == 0));
        check($sformatf("equal op%0d", o), 64'(equal), 64'(a == b));
        check($sformatf("carry op%0d", o), 64'(carry), 64'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint unsigned er;
        bit ec;
        int cnt;
        logic [2:0] ro;
        logic [W-1:0] ra, rb;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; ina = '0; inb = '0;
        v8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out", 64'(out), 64'd0);
        check("rst flags", {61'd0, zero, equal, carry}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post-rst in_ready", 64'(in_ready), 64'd1);

        // Directed cases
        run_op(ADD, 16'hFFFF, 16'h0001);
        check("add wrap out", 64'(out), 64'h0);
        check("add wrap carry", 64'(carry), 64'd1);
        run_op(SUB, 16'h0004, 16'h0004);
        run_op(SUB, 16'h0003, 16'h0004);
        check("sub borrow out", 64'(out), 64'hFFFF);
        run_op(MUL, 16'h0100, 16'h0101);
        check("mul overflow out", 64'(out), 64'h0100);
        check("mul overflow carry", 64'(carry), 64'd1);
        run_op(MUL, 16'h00FF, 16'h0002);
        check("mul small out", 64'(out), 64'h01FE);
        run_op(SHL, 16'h8001, 16'h0001);
        check("shl out", 64'(out), 64'h0002);
        run_op(SHR, 16'h0003, 16'h0011);
        check("shr out", 64'(out), 64'h0001);
        run_op(SHL, 16'h1234, 16'h0010);
        check("shl s0 out", 64'(out), 64'h1234);
        tick();

        // Backpressure: result and flags held while the consumer stalls; a
        // pending op is not taken until OUT_READY returns.
        out_ready = 1'b0;
        run_op(AND_, 16'h0004, 16'h0004);
        op = XOR_; ina = 16'h0004; inb = 16'h0003; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall valid", 64'(out_valid), 64'd1);
            check("stall out", 64'(out), 64'h0004);
            check("stall flags", {61'd0, zero, equal, carry}, 64'b010);
            check("stall in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'd1);
        tick();
        check("xor valid", 64'(out_valid), 64'd1);
        check("xor out", 64'(out), 64'h0007);

        // Streaming: a new non-MUL op every cycle.
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 6));
            ra = W'($urandom); rb = W'($urandom);
            model(ro, ra, rb, W, er, ec);
            op = ro; ina = ra; inb = rb; in_valid = 1'b1;
            tick();
            check("stream valid", 64'(out_valid), 64'd1);
            check($sformatf("stream out op%0d", ro), 64'(out), er);
            check("stream carry", 64'(carry), 64'(ec));
            check("stream equal", 64'(equal), 64'(ra == rb));
        end
        in_valid = 1'b0;
        tick();
        check("stream drain", 64'(out_valid), 64'd0);

        // Random ops, MUL included.
        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_op(ro, ra, rb);
        end
        tick();

        // Reset during a multiply discards it.
        op = MUL; ina = 16'h1234; inb = 16'h5678; in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midmul rst in_ready", 64'(in_ready), 64'd0);
        check("midmul rst out_valid", 64'(out_valid), 64'd0);
        check("midmul rst out", 64'(out), 64'd0);
        check("midmul rst flags", {61'd0, zero, equal, carry}, 64'd0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid) cnt++;
            tick();
        end
        check("no partial result", 64'(cnt), 64'd0);
        run_op(ADD, 16'h0001, 16'h0001);
        check("post-rst add out", 64'(out), 64'h0002);

        // 8-bit instance
        op8 = ADD; a8 = 8'hFF; b8 = 8'h01; v8 = 1'b1;
        #1;
        check("w8 in_ready", 64'(r8), 64'd1);
        tick();
        v8 = 1'b0;
        check("w8 valid", 64'(ov8), 64'd1);
        check("w8 out", 64'(o8), 64'h00);
        check("w8 carry", 64'(c8), 64'd1);
        check("w8 zero", 64'(z8), 64'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
